// File: rtl/rr_regbank_arbiter.sv
// rr_regbank_arbiter: round-robin arbiter in front of a small bank of
// preset/clear-capable registers. An init sweep clears the bank one entry
// per cycle after reset or on init_req; afterwards one requester per cycle
// is granted and its command (NOP/LOAD/PRESET/CLEAR) is applied to the bank.
//
// Handshake: a requester holds req (with stable op/addr/wdata) until it sees
// its one-cycle gnt pulse, which appears the cycle after the winning edge.
// During the gnt cycle the requester drops req or presents a new command;
// req still high on the following edge counts as a brand new request.
module rr_regbank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [AW*NREQ-1:0]    addr,
    input  logic [WIDTH*NREQ-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_PRESET = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic [WIDTH-1:0]  bank_q [DEPTH];
    logic [WIDTH-1:0]  bank_d [DEPTH];

    logic [NREQ-1:0]   elig;
    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand_idx;
    logic [1:0]        win_op;
    logic [AW-1:0]     win_addr;
    logic [WIDTH-1:0]  win_data;

    // Pick the first eligible requester at or after ptr, wrapping; the
    // requester currently holding gnt is masked so its stale req is ignored.
    always_comb begin
        elig      = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand_idx = PW'((int'(ptr_q) + off) % NREQ);
            if (!win_found && elig[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Winner's command fields, sliced out of the packed request buses.
    always_comb begin
        win_op   = op[int'(win_idx)*2 +: 2];
        win_addr = addr[int'(win_idx)*AW +: AW];
        win_data = wdata[int'(win_idx)*WIDTH +: WIDTH];
    end

    // Next-state, grant, pointer and bank update; init_req cancels this
    // edge's arbitration and restarts the sweep.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        bank_d  = bank_q;

        case (state_q)
            ST_INIT: begin
                bank_d[idx_q] = '0;
                if (idx_q == AW'(DEPTH - 1)) begin
                    idx_d   = '0;
                    state_d = ST_ARB;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_ARB: begin
                if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = PW'((int'(win_idx) + 1) % NREQ);
                    case (win_op)
                        OP_LOAD:   bank_d[win_addr] = win_data;
                        OP_PRESET: bank_d[win_addr] = '1;
                        OP_CLEAR:  bank_d[win_addr] = '0;
                        OP_NOP:    bank_d[win_addr] = bank_q[win_addr];
                        default:   bank_d[win_addr] = bank_q[win_addr];
                    endcase
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase

        if (init_req) begin
            state_d = ST_INIT;
            idx_d   = '0;
            ptr_d   = ptr_q;
            gnt_d   = '0;
            bank_d  = bank_q;
        end
    end

    // Read port samples the pre-edge contents, so same-edge writes show up
    // one cycle later.
    always_comb begin
        rd_data_d = bank_q[rd_addr];
    end

    // Control registers with synchronous reset into the init sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            idx_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Bank storage has no reset; the sweep clears it. Writes are held off
    // while rst is high so a cancelled grant never lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q == ST_INIT);
    assign rd_data   = rd_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_regbank_arbiter.sv
// Directed bench for rr_regbank_arbiter (NREQ=4, WIDTH=8, DEPTH=4).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_rr_regbank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  rr_regbank_arbiter #(
    .NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2)
  ) dut (
    .clk(clk), .rst(rst), .init_req(init_req),
    .req(req), .op(op), .addr(addr), .wdata(wdata),
    .gnt(gnt), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [1:0] a,
                         input logic [7:0] d);
    op[2*i +: 2]    = o;
    addr[2*i +: 2]  = a;
    wdata[8*i +: 8] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] rr_exp [5];
  logic [3:0] alt_exp [4];
  logic [3:0] solo_exp [4];

  initial begin
    rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    alt_exp  = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
    solo_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};

    rst = 1'b1; init_req = 1'b0; req = '0; op = '0; addr = '0; wdata = '0;
    rd_addr = '0;

    // reset values
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_rd", 32'(rd_data), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;

    // sweep: busy for 4 cycles after rst drops
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("sweep_busy", 32'(busy), 32'h1);
      chk("sweep_gnt", 32'(gnt), 32'h0);
    end
    step();
    chk("sweep_done_busy", 32'(busy), 32'h0);
    chk("sweep_done_state", 32'(dbg_state), 32'h1);

    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      step();
      chk("sweep_rd", 32'(rd_data), 32'h0);
    end

    // single LOAD / PRESET / CLEAR from requester 2 to addr 1
    rd_addr = 2'd1;
    set_req(2, 2'b01, 2'd1, 8'hA5); req = 4'b0100;
    step();
    chk("load_gnt", 32'(gnt), 32'h4);
    req = '0;
    step();
    chk("load_rd", 32'(rd_data), 32'hA5);
    chk("load_gnt_drop", 32'(gnt), 32'h0);

    set_req(2, 2'b10, 2'd1, 8'h00); req = 4'b0100;
    step();
    chk("preset_gnt", 32'(gnt), 32'h4);
    chk("preset_rd_old", 32'(rd_data), 32'hA5);
    req = '0;
    step();
    chk("preset_rd", 32'(rd_data), 32'hFF);

    set_req(2, 2'b11, 2'd1, 8'h00); req = 4'b0100;
    step();
    chk("clear_gnt", 32'(gnt), 32'h4);
    chk("clear_rd_old", 32'(rd_data), 32'hFF);
    req = '0;
    step();
    chk("clear_rd", 32'(rd_data), 32'h00);

    // NOP from requester 3 moves ptr back to 0
    set_req(3, 2'b00, 2'd0, 8'h00); req = 4'b1000;
    step();
    chk("nop_gnt", 32'(gnt), 32'h8);
    req = '0;
    step();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // round robin with all requesters held
    op = '0; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
    end
    req = '0;
    step();
    chk("rr_idle", 32'(gnt), 32'h0);

    // two requesters alternate (ptr is 1 here)
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("alt_gnt", 32'(gnt), 32'(alt_exp[k]));
    end
    // lone requester held: granted every other cycle
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("solo_gnt", 32'(gnt), 32'(solo_exp[k]));
    end
    req = '0;
    step();

    // init_req mid-traffic
    set_req(2, 2'b01, 2'd1, 8'hA5); req = 4'b0100;
    step();
    chk("pre_init_gnt", 32'(gnt), 32'h4);
    set_req(1, 2'b01, 2'd2, 8'h3C); req = 4'b0010; init_req = 1'b1;
    step();
    chk("init_gnt", 32'(gnt), 32'h0);
    chk("init_busy", 32'(busy), 32'h1);
    init_req = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      chk("init_sweep_gnt", 32'(gnt), 32'h0);
      chk("init_sweep_busy", 32'(busy), 32'h1);
    end
    step();
    chk("init_end_gnt", 32'(gnt), 32'h0);
    chk("init_end_busy", 32'(busy), 32'h0);
    rd_addr = 2'd1;
    step();
    chk("init_resume_gnt", 32'(gnt), 32'h2);
    chk("init_cleared_rd", 32'(rd_data), 32'h00);
    req = '0; rd_addr = 2'd2;
    step();
    chk("init_resume_rd", 32'(rd_data), 32'h3C);

    // reset while a grant is showing
    set_req(1, 2'b00, 2'd0, 8'h00); req = 4'b0010;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    set_req(3, 2'b00, 2'd0, 8'h00); req = 4'b1010; rst = 1'b1;
    step();
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      chk("rst_sweep_busy", 32'(busy), 32'h1);
      chk("rst_sweep_gnt", 32'(gnt), 32'h0);
    end
    step();
    chk("rst_sweep_end_busy", 32'(busy), 32'h0);
    chk("rst_sweep_end_gnt", 32'(gnt), 32'h0);
    step();
    chk("post_rst_first_gnt", 32'(gnt), 32'h2);
    step();
    chk("post_rst_second_gnt", 32'(gnt), 32'h8);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
